cordic_sched: RTL and testbench
===============================

CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: maximum clk_100m cycles to wait for core_done after core_start.
REQ-002 Parameter HYP_LIMIT, default 72089: saturation magnitude for hyperbolic/exp arguments, Q16.16 (about 1.1).
REQ-003 clk_100m  input  1: the single clock; all logic is on its rising edge.
REQ-004 rst_n  input  1: asynchronous active-low reset.
REQ-005 mode_btn_pulse  input  1: one-cycle debounced press; advances the mode.
REQ-006 sample_tick  input  1: one-cycle request to start a computation.
REQ-007 adc_ch1_data  input  10: unsigned ADC code; midscale 512 = argument 0.
REQ-008 core_start  output  1: one-cycle start pulse to the CORDIC core.
REQ-009 core_func  output  2: core function, 1 = sin/cos, 2 = sinh/cosh, 3 = exp.
REQ-010 core_arg  output  32: signed Q16.16 argument to the core.
REQ-011 core_done  input  1: one-cycle completion pulse from the core.
REQ-012 core_r1, core_r2  input  32 each: core results, valid when core_done = 1.
REQ-013 cordic_mode  output  2: current mode, 0 = disabled, 1 = sin/cos, 2 = sinh/cosh, 3 = exp.
REQ-014 cordic_result_1, cordic_result_2  output  32 each: latched results, signed Q16.16.
REQ-015 cordic_result_valid  output  1: one-cycle pulse when new results are latched.
REQ-016 err_timeout  output  1: sticky flag; cleared only by reset or by a mode change.

Function
REQ-017 Each mode_btn_pulse SHALL advance cordic_mode 0→1→2→3→0, wrapping from 3 to 0, and SHALL clear err_timeout.
REQ-018 Argument formation SHALL use d = signed(adc_ch1_data − 512), range −512..511.
- Mode 1: arg = d·402 (π/2 per 256 codes); 768 → 102912.
- Modes 2 and 3: arg = d·145; 738 → 32770.
- Modes 2 and 3: arg SHALL saturate to ±HYP_LIMIT.
REQ-019 Argument computation SHALL be full-precision signed, at least 21 bits before sign-extension to 32 bits.
REQ-020 The FSM states SHALL be IDLE, ISSUE, WAIT and LATCH.
REQ-021 IDLE→ISSUE SHALL occur when cordic_mode ≠ 0 and (sample_tick = 1 or pending = 1).
REQ-022 In ISSUE:
- core_arg and core_func are captured from the current ADC code and mode into a snapshot.
- core_start = 1 for exactly that one cycle.
- Next state is WAIT.
REQ-023 core_arg and core_func SHALL hold their snapshot values from ISSUE until the FSM leaves WAIT.
REQ-024 In WAIT:
- core_done → LATCH.
- TIMEOUT_CYC cycles without core_done → set err_timeout, go to IDLE, no valid pulse.
REQ-025 In LATCH:
- core_r1/core_r2 captured on the core_done cycle go to cordic_result_1/2.
- cordic_result_valid = 1 for this single cycle, so valid is 1 cycle after core_done.
- Next state is IDLE.
REQ-026 A sample_tick arriving in ISSUE, WAIT or LATCH SHALL set a one-deep pending flag; multiple ticks coalesce into one.
- pending clears on entry to ISSUE.
REQ-027 A mode change during ISSUE or WAIT SHALL mark the operation stale.
- The FSM still waits for core_done or timeout.
- No result latch and no valid pulse occur for the stale operation.
- pending clears.
REQ-028 In mode 0: no core_start is issued, pending clears, and cordic_result_1/2 hold their last values.
REQ-029 A sample_tick in IDLE coincident with mode_btn_pulse SHALL issue using the new mode.
REQ-030 A core_done outside WAIT SHALL be ignored.

Reset
REQ-031 While rst_n = 0, all of the following SHALL hold:
- cordic_mode = 0 and FSM = IDLE.
- core_start = 0, core_func = 0, core_arg = 0.
- cordic_result_1 = 0, cordic_result_2 = 0, cordic_result_valid = 0.
- err_timeout = 0 and pending = 0.
REQ-032 Reset asserted mid-operation SHALL abort immediately, with no valid pulse after release.

Verification
REQ-033 Four mode_btn_pulse from reset → cordic_mode 1, 2, 3, 0; no core_start is ever issued in mode 0.
REQ-034 Mode 1, adc = 768, sample_tick, stub core_done after 20 cycles with r1 = 65536, r2 = 0:
- core_arg = 102912 and core_func = 1.
- valid pulses one cycle after core_done.
- cordic_result_1 = 65536.
REQ-035 Mode 3, adc = 1023 → core_arg = 72089 (saturated); adc = 0 → core_arg = −72089; adc = 738 → 32770.
REQ-036 Mode 1, stub never asserts core_done:
- err_timeout sets 64 cycles after core_start, with no valid pulse.
- A subsequent mode_btn_pulse clears err_timeout.
REQ-037 Three sample_ticks during WAIT → exactly one further core_start after LATCH.
REQ-038 mode_btn_pulse during WAIT, followed by core_done:
- No valid pulse; results unchanged.
- Next tick issues with the new core_func.

Source files
------------

// File: rtl/cordic_sched_if.sv
// Handshake and data bundle between the CORDIC scheduler and the CORDIC core.
interface cordic_sched_if;
  logic               core_start;
  logic [1:0]         core_func;
  logic signed [31:0] core_arg;
  logic               core_done;
  logic signed [31:0] core_r1;
  logic signed [31:0] core_r2;

  modport master (
    output core_start, core_func, core_arg,
    input  core_done, core_r1, core_r2
  );

  modport slave (
    input  core_start, core_func, core_arg,
    output core_done, core_r1, core_r2
  );
endinterface

// File: rtl/cordic_sched.sv
// Mode selection and request scheduling for an external CORDIC core: forms the
// Q16.16 argument from the ADC code, issues one job at a time, latches results.
module cordic_sched #(
  parameter int TIMEOUT_CYC = 64,
  parameter int HYP_LIMIT   = 72089
) (
  input  logic               clk_100m,
  input  logic               rst_n,
  input  logic               mode_btn_pulse,
  input  logic               sample_tick,
  input  logic [9:0]         adc_ch1_data,
  cordic_sched_if.master     core,
  output logic [1:0]         cordic_mode,
  output logic signed [31:0] cordic_result_1,
  output logic signed [31:0] cordic_result_2,
  output logic               cordic_result_valid,
  output logic               err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic signed [20:0] HYP_MAX = 21'(HYP_LIMIT);
  localparam logic signed [20:0] HYP_MIN = 21'(-HYP_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LATCH} state_t;

  state_t           state_q, state_d;
  logic             pending_q;
  logic             stale_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       mode_nxt;
  logic             start_op;
  logic             done_ok;
  logic             timeout_hit;

  function automatic logic signed [20:0] sat_hyp(input logic signed [20:0] v);
    if (v > HYP_MAX) return HYP_MAX;
    if (v < HYP_MIN) return HYP_MIN;
    return v;
  endfunction

  // d spans -512..511, so both products fit in 21 signed bits before extension.
  function automatic logic signed [31:0] form_arg(input logic [9:0] code, input logic [1:0] func);
    logic signed [20:0] d;
    logic signed [20:0] prod;
    d = $signed({11'd0, code}) - 21'sd512;
    if (func == 2'd1) prod = d * 21'sd402;
    else              prod = sat_hyp(d * 21'sd145);
    return 32'(prod);
  endfunction

  // A press coincident with a tick in IDLE issues with the mode it advances to.
  assign mode_nxt    = mode_btn_pulse ? cordic_mode + 2'd1 : cordic_mode;
  assign start_op    = (state_q == IDLE) && (mode_nxt != 2'd0) && (sample_tick || pending_q);
  assign done_ok     = !stale_q && !mode_btn_pulse;
  assign timeout_hit = (state_q == WAIT) && !core.core_done && (cnt_q == CNT_LAST);

  assign core.core_start     = (state_q == ISSUE);
  assign cordic_result_valid = (state_q == LATCH);

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_op) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (core.core_done) state_d = done_ok ? LATCH : IDLE;
        else if (timeout_hit) state_d = IDLE;
      end
      LATCH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      cordic_mode     <= 2'd0;
      err_timeout     <= 1'b0;
      pending_q       <= 1'b0;
      stale_q         <= 1'b0;
      cnt_q           <= '0;
      core.core_func  <= 2'd0;
      core.core_arg   <= 32'sd0;
      cordic_result_1 <= 32'sd0;
      cordic_result_2 <= 32'sd0;
    end else begin
      cordic_mode <= mode_nxt;

      if (mode_btn_pulse)   err_timeout <= 1'b0;
      else if (timeout_hit) err_timeout <= 1'b1;

      // Snapshot stays on the core bus until the next issue.
      if (start_op) begin
        pending_q      <= 1'b0;
        stale_q        <= 1'b0;
        cnt_q          <= '0;
        core.core_func <= mode_nxt;
        core.core_arg  <= form_arg(adc_ch1_data, mode_nxt);
      end else begin
        if (state_q == ISSUE || state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);
        if (mode_btn_pulse && (state_q == ISSUE || state_q == WAIT)) begin
          stale_q   <= 1'b1;
          pending_q <= 1'b0;
        end else if (sample_tick && state_q != IDLE) begin
          pending_q <= 1'b1;
        end else if (state_q == IDLE && mode_nxt == 2'd0) begin
          pending_q <= 1'b0;
        end
      end

      if (state_q == WAIT && core.core_done && done_ok) begin
        cordic_result_1 <= core.core_r1;
        cordic_result_2 <= core.core_r2;
      end
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// Scoreboard bench for cordic_sched with a stub CORDIC core and a reference model.
module tb_cordic_sched;
  localparam int HYP_LIMIT = 72089;
  localparam int TIMEOUT   = 64;

  typedef struct { int func; int arg; } start_t;
  typedef struct { int r1;   int r2;  } res_t;

  logic               clk_100m = 1'b0;
  logic               rst_n = 1'b0;
  logic               mode_btn_pulse = 1'b0;
  logic               sample_tick = 1'b0;
  logic [9:0]         adc_ch1_data = 10'd512;
  logic [1:0]         cordic_mode;
  logic signed [31:0] cordic_result_1, cordic_result_2;
  logic               cordic_result_valid, err_timeout;

  cordic_sched_if cif();

  cordic_sched #(.TIMEOUT_CYC(TIMEOUT), .HYP_LIMIT(HYP_LIMIT)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .mode_btn_pulse(mode_btn_pulse),
    .sample_tick(sample_tick), .adc_ch1_data(adc_ch1_data), .core(cif),
    .cordic_mode(cordic_mode), .cordic_result_1(cordic_result_1),
    .cordic_result_2(cordic_result_2), .cordic_result_valid(cordic_result_valid),
    .err_timeout(err_timeout)
  );

  always #5 clk_100m = ~clk_100m;

  int     vectors = 0, miscompares = 0;
  int     cyc = 0, last_done = -100, start_cyc = 0;
  int     model_mode = 0, model_r1 = 0, model_r2 = 0;
  int     stub_delay = 0, stub_r1 = 0, stub_r2 = 0;
  start_t exp_start[$];
  res_t   exp_res[$];

  always @(posedge clk_100m) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int arg_model(input int mode, input int code);
    int d, v;
    d = code - 512;
    if (mode == 1) return d * 402;
    v = d * 145;
    if (v > HYP_LIMIT)  v = HYP_LIMIT;
    if (v < -HYP_LIMIT) v = -HYP_LIMIT;
    return v;
  endfunction

  // Stub core: answers each start after stub_delay cycles; delay 0 means never.
  initial begin
    int d, v1, v2;
    cif.core_done = 1'b0; cif.core_r1 = '0; cif.core_r2 = '0;
    forever begin
      @(negedge clk_100m);
      if (cif.core_start && stub_delay != 0) begin
        d = stub_delay; v1 = stub_r1; v2 = stub_r2;
        repeat (d) @(posedge clk_100m);
        #1 cif.core_done = 1'b1; cif.core_r1 = v1; cif.core_r2 = v2;
        @(posedge clk_100m);
        #1 cif.core_done = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a start or a result.
  initial begin
    start_t es;
    res_t   er;
    forever begin
      @(negedge clk_100m);
      if (rst_n) begin
        if (cif.core_done) last_done = cyc;
        if (cif.core_start) begin
          start_cyc = cyc;
          if (exp_start.size() == 0) begin
            chk("unexpected_core_start_func", cif.core_func, -1);
          end else begin
            es = exp_start.pop_front();
            chk("core_func", cif.core_func, es.func);
            chk("core_arg", cif.core_arg, es.arg);
          end
        end
        if (cordic_result_valid) begin
          if (exp_res.size() == 0) begin
            chk("unexpected_valid_r1", cordic_result_1, -1);
          end else begin
            er = exp_res.pop_front();
            chk("valid_latency", cyc - last_done, 1);
            chk("result_1", cordic_result_1, er.r1);
            chk("result_2", cordic_result_2, er.r2);
            model_r1 = er.r1; model_r2 = er.r2;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_100m);
    #1;
  endtask

  task automatic pulse(input bit btn, input bit tick);
    @(posedge clk_100m); #1;
    mode_btn_pulse = btn; sample_tick = tick;
    @(posedge clk_100m); #1;
    mode_btn_pulse = 1'b0; sample_tick = 1'b0;
    if (btn) model_mode = (model_mode + 1) % 4;
  endtask

  task automatic press_chk();
    pulse(1'b1, 1'b0);
    chk("cordic_mode", cordic_mode, model_mode);
  endtask

  task automatic push_start(input int func, input int arg);
    start_t s;
    s.func = func; s.arg = arg;
    exp_start.push_back(s);
  endtask

  task automatic push_res(input int r1, input int r2);
    res_t r;
    r.r1 = r1; r.r2 = r2;
    exp_res.push_back(r);
  endtask

  // One complete job in the current mode; exp_arg < -1e9 selects the model.
  task automatic run_op(input int code, input int delay, input int exp_arg);
    adc_ch1_data = 10'(code);
    stub_delay = delay;
    stub_r1 = int'($urandom); stub_r2 = int'($urandom);
    if (model_mode != 0) begin
      push_start(model_mode, (exp_arg < -1000000000) ? arg_model(model_mode, code) : exp_arg);
      if (delay != 0) push_res(stub_r1, stub_r2);
    end
    pulse(1'b0, 1'b1);
    cycles(delay + 8);
  endtask

  task automatic reset_chk();
    chk("rst_mode", cordic_mode, 0);
    chk("rst_core_start", cif.core_start, 0);
    chk("rst_core_func", cif.core_func, 0);
    chk("rst_core_arg", cif.core_arg, 0);
    chk("rst_result_1", cordic_result_1, 0);
    chk("rst_result_2", cordic_result_2, 0);
    chk("rst_valid", cordic_result_valid, 0);
    chk("rst_err", err_timeout, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0;
    cycles(3);
    reset_chk();
    rst_n = 1'b1;
    cycles(2);

    // Mode walk 1,2,3,0 and ticks while disabled.
    repeat (4) press_chk();
    run_op(900, 5, -2000000000);
    chk("mode0_hold_r1", cordic_result_1, 0);

    // Trig argument and basic latch.
    press_chk();
    adc_ch1_data = 10'd768; stub_delay = 20; stub_r1 = 65536; stub_r2 = 0;
    push_start(1, 102912); push_res(65536, 0);
    pulse(1'b0, 1'b1);
    cycles(28);
    chk("sincos_result_1", cordic_result_1, 65536);

    // Hyperbolic and exp arguments, including saturation.
    press_chk();
    run_op(300, 4, -2000000000);
    press_chk();
    run_op(1023, 3, 72089);
    run_op(0, 3, -72089);
    run_op(738, 3, 32770);

    // Disabled mode keeps results.
    press_chk();
    run_op(100, 3, -2000000000);
    chk("mode0_hold_r1b", cordic_result_1, model_r1);
    chk("mode0_hold_r2b", cordic_result_2, model_r2);

    // Timeout with no core_done.
    press_chk();
    run_op(600, 0, -2000000000);
    n = 0;
    t0 = start_cyc;
    while (!err_timeout && n < 100) begin
      @(negedge clk_100m); n++;
    end
    chk("timeout_latency", cyc - t0, TIMEOUT);
    cycles(3);
    press_chk();
    chk("err_cleared_by_mode", err_timeout, 0);

    // Three ticks during WAIT coalesce into one further job.
    adc_ch1_data = 10'd400; stub_delay = 20;
    stub_r1 = int'($urandom); stub_r2 = int'($urandom);
    push_start(2, arg_model(2, 400)); push_res(stub_r1, stub_r2);
    push_start(2, arg_model(2, 400)); push_res(stub_r1, stub_r2);
    pulse(1'b0, 1'b1);
    repeat (3) pulse(1'b0, 1'b1);
    cycles(60);

    // Mode change during WAIT makes the job stale.
    adc_ch1_data = 10'd200; stub_delay = 20;
    stub_r1 = 12345; stub_r2 = 54321;
    push_start(2, arg_model(2, 200));
    pulse(1'b0, 1'b1);
    cycles(4);
    press_chk();
    cycles(30);
    chk("stale_hold_r1", cordic_result_1, model_r1);
    chk("stale_hold_r2", cordic_result_2, model_r2);
    run_op(800, 5, -2000000000);

    // Tick coincident with press in IDLE: 3->0 issues nothing, 0->1 issues sin/cos.
    adc_ch1_data = 10'd700; stub_delay = 5;
    pulse(1'b1, 1'b1);
    cycles(10);
    push_start(1, arg_model(1, 700)); push_res(stub_r1, stub_r2);
    pulse(1'b1, 1'b1);
    cycles(15);

    // Randomized jobs across modes.
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 3);
      if (n == 3) n = 0;
      repeat (n) pulse(1'b1, 1'b0);
      run_op($urandom_range(0, 1023), $urandom_range(1, 30), -2000000000);
    end

    // Reset in the middle of a job: no result afterwards.
    if (model_mode == 0) pulse(1'b1, 1'b0);
    adc_ch1_data = 10'd555; stub_delay = 20;
    push_start(model_mode, arg_model(model_mode, 555));
    pulse(1'b0, 1'b1);
    cycles(5);
    rst_n = 1'b0;
    model_mode = 0;
    cycles(2);
    reset_chk();
    rst_n = 1'b1;
    cycles(40);
    chk("post_reset_r1", cordic_result_1, 0);

    chk("start_queue_empty", exp_start.size(), 0);
    chk("result_queue_empty", exp_res.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
